axi_mem_responder: RTL

AXI4 memory-mapped slave (responder) backed by an on-chip byte-writable RAM, serving the reduced AXI4 master port used by the instruction-memory and buffer wrappers (AW/W/B, AR/R with addr, len, valid/ready, data, strb, last). It is the far end of those masters: a synthesizable DDR stand-in for on-chip bring-up and the target for wrapper-level verification. Read and write channels run independent state machines sharing one dual-port RAM.

---
 rtl/axi_mem_pkg.sv | 22 ++
 rtl/axi_mem_bram.sv | 33 +++
 rtl/axi_mem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory responder: channel state encodings and
// the byte-offset width helper.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

  // Number of address bits that select a byte within one data beat.
  function automatic int off_w_of(input int strb_w);
    return $clog2(strb_w);
  endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read
// port, read-first on a same-word collision. Contents are never reset.
module axi_mem_bram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Sampling the array before the write lands gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip RAM; independent write and read FSMs share
// one dual-port RAM. INCR bursts only, one burst in flight per channel.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write burst address
// W_DATA  | wready high, accepting beats until the count runs out
// W_RESP  | bvalid high, waiting for bready
// R_IDLE  | arready high, waiting for a read burst address
// R_FETCH | RAM read issued for the current beat
// R_DATA  | rvalid high, rdata/rlast held until rready
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 42,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_BURST_WIDTH = 8,
  parameter int WSTRB_W         = AXI_DATA_WIDTH / 8,
  parameter int MEM_ADDR_W      = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [AXI_BURST_WIDTH-1:0] s_awlen,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  s_wdata,
  input  logic [WSTRB_W-1:0]         s_wstrb,
  input  logic                       s_wlast,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
  input  logic [AXI_BURST_WIDTH-1:0] s_arlen,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
  output logic                       s_rlast,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic                       wlast_err
);

  localparam int OFF_W = off_w_of(WSTRB_W);

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [MEM_ADDR_W-1:0]      w_idx, r_idx;
  logic [AXI_BURST_WIDTH-1:0] w_cnt, r_cnt;
  logic [AXI_DATA_WIDTH-1:0]  ram_rdata;
  logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                       ram_re;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^{s_awaddr[AXI_ADDR_WIDTH-1:MEM_ADDR_W+OFF_W], s_awaddr[OFF_W-1:0],
                              s_araddr[AXI_ADDR_WIDTH-1:MEM_ADDR_W+OFF_W], s_araddr[OFF_W-1:0]};

  assign aw_hs = (w_state == W_IDLE) && s_awvalid;
  assign w_hs  = (w_state == W_DATA) && s_wvalid;
  assign b_hs  = (w_state == W_RESP) && s_bready;
  assign ar_hs = (r_state == R_IDLE) && s_arvalid;
  assign r_hs  = (r_state == R_DATA) && s_rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && (w_cnt == '0)) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA:  if (r_hs) r_state_nxt = (r_cnt == '0) ? R_IDLE : R_FETCH;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_awready = (w_state == W_IDLE);
    s_wready  = (w_state == W_DATA);
    s_bvalid  = (w_state == W_RESP);
    s_arready = (r_state == R_IDLE);
    s_rvalid  = (r_state == R_DATA);
    s_rlast   = (r_state == R_DATA) && (r_cnt == '0);
    s_rdata   = (r_state == R_DATA) ? ram_rdata : '0;
    ram_re    = (r_state == R_FETCH);
  end

  // Burst bookkeeping; the write burst ends on the count, wlast is only audited.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_idx     <= '0;
      w_cnt     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= s_awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
        w_cnt <= s_awlen;
      end else if (w_hs) begin
        w_idx <= w_idx + MEM_ADDR_W'(1);
        w_cnt <= w_cnt - AXI_BURST_WIDTH'(1);
        if (s_wlast != (w_cnt == '0)) wlast_err <= 1'b1;
      end
      if (ar_hs) begin
        r_idx <= s_araddr[MEM_ADDR_W+OFF_W-1:OFF_W];
        r_cnt <= s_arlen;
      end else if (r_hs) begin
        r_idx <= r_idx + MEM_ADDR_W'(1);
        r_cnt <= r_cnt - AXI_BURST_WIDTH'(1);
      end
    end
  end

  axi_mem_bram #(
    .DATA_W (AXI_DATA_WIDTH),
    .ADDR_W (MEM_ADDR_W),
    .STRB_W (WSTRB_W)
  ) u_bram (
    .clk   (clk),
    .we    (w_hs),
    .waddr (w_idx),
    .wdata (s_wdata),
    .wstrb (s_wstrb),
    .re    (ram_re),
    .raddr (r_idx),
    .rdata (ram_rdata)
  );

endmodule
